// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store requesters.
// Data has priority; a starvation counter forces a fetch grant after MAX_WAIT data grants.
module mem_port_arbiter #(
  parameter int AW       = 64,
  parameter int DW       = 64,
  parameter int MAX_WAIT = 2,
  parameter int CW       = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    owner
);

  // state  | meaning
  // IDLE   | arbitrate between if_req and d_req at each edge
  // IF_MEM | fetch transaction on the memory port, waiting for mem_ack
  // D_MEM  | load/store transaction on the memory port, waiting for mem_ack
  // RESP   | one-cycle acknowledge to the winning requester
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_MEM = 2'd1,
    D_MEM  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  state_t          state, state_nxt;
  logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
  logic            mem_req_nxt, mem_we_nxt;
  logic [AW-1:0]   mem_addr_nxt;
  logic [DW-1:0]   mem_wdata_nxt;
  logic [DW-1:0]   if_rdata_nxt, d_rdata_nxt;
  logic            if_ack_nxt, d_ack_nxt;
  logic [1:0]      owner_nxt;
  logic            grant_d;

  assign grant_d = d_req && (!if_req || (wait_cnt < WAIT_MAX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      owner     <= 2'b00;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      if_ack    <= if_ack_nxt;
      d_ack     <= d_ack_nxt;
      owner     <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    if_ack_nxt    = 1'b0;
    d_ack_nxt     = 1'b0;
    owner_nxt     = owner;

    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt     = D_MEM;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          owner_nxt     = 2'b10;
          if (if_req && (wait_cnt != WAIT_MAX))
            wait_cnt_nxt = wait_cnt + CW'(1);
        end else if (if_req) begin
          state_nxt    = IF_MEM;
          mem_req_nxt  = 1'b1;
          mem_we_nxt   = 1'b0;
          mem_addr_nxt = if_addr;
          owner_nxt    = 2'b01;
          wait_cnt_nxt = '0;
        end
      end

      IF_MEM: begin
        if (mem_ack) begin
          state_nxt    = RESP;
          mem_req_nxt  = 1'b0;
          mem_we_nxt   = 1'b0;
          if_rdata_nxt = mem_rdata;
          if_ack_nxt   = 1'b1;
        end
      end

      D_MEM: begin
        if (mem_ack) begin
          state_nxt   = RESP;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          d_rdata_nxt = mem_rdata;
          d_ack_nxt   = 1'b1;
        end
      end

      RESP: begin
        state_nxt = IDLE;
        owner_nxt = 2'b00;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MAX_WAIT = 2;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [1:0]    owner;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .CW(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // reference model: arbitration history and last-captured values
  int            m_wait;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  logic [DW-1:0] m_if_rdata;
  logic [DW-1:0] m_d_rdata;
  string         grants;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_wait = 0;
    m_addr = '0;
    m_wdata = '0;
    m_we = 1'b0;
    m_if_rdata = '0;
    m_d_rdata = '0;
  endtask

  // Entered #1 into a cycle where the DUT should be IDLE, with requests already driven.
  // Returns #1 into the following IDLE cycle.
  task automatic step_txn(input int lat, input logic [DW-1:0] rd, input bit noise, input bit early);
    bit win_d;
    mem_ack = noise;
    mem_rdata = rnd64();
    @(negedge clk);
    check_eq("idle_mem_req", mem_req, 1'b0);
    check_eq("idle_if_ack", if_ack, 1'b0);
    check_eq("idle_d_ack", d_ack, 1'b0);
    check_eq("idle_owner", owner, 2'b00);
    check_eq("idle_mem_addr", mem_addr, m_addr);
    check_eq("idle_if_rdata", if_rdata, m_if_rdata);
    check_eq("idle_d_rdata", d_rdata, m_d_rdata);
    if (!if_req && !d_req) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      return;
    end
    win_d = d_req && (!if_req || m_wait < MAX_WAIT);
    if (win_d) begin
      if (if_req && m_wait < MAX_WAIT) m_wait = m_wait + 1;
      m_addr = d_addr;
      m_wdata = d_wdata;
      m_we = d_we;
      grants = {grants, "D"};
    end else begin
      m_wait = 0;
      m_addr = if_addr;
      m_we = 1'b0;
      grants = {grants, "F"};
    end
    @(posedge clk); #1;
    for (int k = 0; k <= lat; k++) begin
      mem_ack = (k == lat);
      mem_rdata = (k == lat) ? rd : rnd64();
      @(negedge clk);
      check_eq("mem_req", mem_req, 1'b1);
      check_eq("mem_we", mem_we, m_we);
      check_eq("mem_addr", mem_addr, m_addr);
      check_eq("mem_wdata", mem_wdata, m_wdata);
      check_eq("owner_busy", owner, win_d ? 2'b10 : 2'b01);
      check_eq("early_ack", {if_ack, d_ack}, 2'b00);
      @(posedge clk); #1;
    end
    mem_ack = noise;
    mem_rdata = rnd64();
    if (win_d) m_d_rdata = rd; else m_if_rdata = rd;
    if (early) begin
      if (win_d && !if_req) begin if_req = 1'b1; if_addr = rnd64(); end
      if (!win_d && !d_req) begin
        d_req = 1'b1; d_addr = rnd64(); d_wdata = rnd64(); d_we = $urandom_range(0, 1);
      end
    end
    @(negedge clk);
    check_eq("resp_if_ack", if_ack, !win_d);
    check_eq("resp_d_ack", d_ack, win_d);
    check_eq("resp_if_rdata", if_rdata, m_if_rdata);
    check_eq("resp_d_rdata", d_rdata, m_d_rdata);
    check_eq("resp_mem_req", mem_req, 1'b0);
    check_eq("resp_mem_addr", mem_addr, m_addr);
    @(posedge clk); #1;
    if (win_d) d_req = 1'b0; else if_req = 1'b0;
    mem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    grants = "";
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_addr", mem_addr, '0);
    check_eq("rst_mem_wdata", mem_wdata, '0);
    check_eq("rst_acks", {if_ack, d_ack, mem_we}, 3'b000);
    check_eq("rst_rdata", if_rdata | d_rdata, '0);
    check_eq("rst_owner", owner, 2'b00);
    @(posedge clk); #1;
    reset = 1'b1;

    // single fetch, zero memory wait
    if_req = 1'b1; if_addr = 64'h40;
    step_txn(0, 64'h8C22_0004, 1'b0, 1'b0);
    check_eq("fetch_word", if_rdata, 64'h8C22_0004);

    // store with three memory wait cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'hDEAD_BEEF;
    step_txn(3, rnd64(), 1'b0, 1'b0);

    // stray mem_ack in IDLE is ignored, then a normal fetch
    repeat (3) step_txn(0, '0, 1'b1, 1'b0);
    if_req = 1'b1; if_addr = 64'h44;
    step_txn(1, rnd64(), 1'b1, 1'b0);

    // both requesters held continuously: D D F D D F
    grants = "";
    for (int i = 0; i < 6; i++) begin
      if (!if_req) begin if_req = 1'b1; if_addr = rnd64(); end
      if (!d_req) begin d_req = 1'b1; d_we = 1'b0; d_addr = rnd64(); d_wdata = rnd64(); end
      step_txn($urandom_range(0, 2), rnd64(), 1'b0, 1'b0);
    end
    check_eq("grant_order", (grants == "DDFDDF"), 1'b1);
    if_req = 1'b0; d_req = 1'b0;
    step_txn(0, '0, 1'b0, 1'b0);

    // reset during D_MEM abandons the transaction
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h200; d_wdata = 64'h1234;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("abort_mem_req_pre", mem_req, 1'b1);
    reset = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort_mem_req", mem_req, 1'b0);
      check_eq("abort_owner", owner, 2'b00);
      check_eq("abort_d_ack", d_ack, 1'b0);
      check_eq("abort_mem_addr", mem_addr, '0);
      @(posedge clk); #1;
    end
    d_req = 1'b1; d_addr = 64'h200; d_we = 1'b0;
    step_txn(2, 64'hCAFE_F00D, 1'b0, 1'b0);
    check_eq("reissue_rdata", d_rdata, 64'hCAFE_F00D);

    // d_req raised in the RESP cycle of a fetch waits for the next IDLE edge
    if_req = 1'b1; if_addr = 64'h80;
    step_txn(0, rnd64(), 1'b0, 1'b1);
    check_eq("late_d_pending", d_req, 1'b1);
    step_txn(0, rnd64(), 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      if (!if_req && $urandom_range(0, 2) != 0) begin if_req = 1'b1; if_addr = rnd64(); end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1'b1; d_we = $urandom_range(0, 1); d_addr = rnd64(); d_wdata = rnd64();
      end
      step_txn($urandom_range(0, 3), rnd64(), $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the instruction-fetch requester (PC side) and the load/store requester (ALU address / writedata side) of the 64-bit MIPS core.
- Data accesses have priority. A starvation counter guarantees that fetch eventually wins.
- Registers each granted transaction and drives the memory port. It returns read data through a one-cycle acknowledge to the winning requester.

Parameters:
- AW, 64, address width (if_addr, d_addr, mem_addr)
- DW, 64, data width (all rdata/wdata buses)
- MAX_WAIT, 2, consecutive data grants allowed while if_req is pending before fetch is forced
- CW, 2, width of the starvation counter; must hold MAX_WAIT

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  AW  fetch address; stable while if_req is high
- if_rdata  out  DW  fetched instruction word; valid when if_ack=1
- if_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address (aluout)
- d_wdata  in  DW  store data (writedata)
- d_rdata  out  DW  load data (readdata); valid when d_ack=1
- d_ack  out  1  one-cycle data completion pulse
- mem_req  out  1  memory transaction request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid when mem_ack=1
- mem_ack  in  1  memory completion; honoured only while mem_req=1
- owner  out  2  00 idle, 01 fetch, 10 data

Behaviour:
- State machine: IDLE, IF_MEM, D_MEM, RESP. All outputs are registered; no combinational path from requester inputs to any output.
- IDLE:
  - Arbitrate at each edge.
  - If d_req=1 and (if_req=0 or wait_cnt<MAX_WAIT): go to D_MEM. Latch d_addr/d_wdata/d_we into the mem_* registers.
  - Else if if_req=1: go to IF_MEM. Latch if_addr; mem_we=0; mem_wdata unchanged.
  - Else stay in IDLE.
- wait_cnt:
  - Increments on a D_MEM grant while if_req=1, saturating at MAX_WAIT.
  - Clears on every IF_MEM grant.
  - Unchanged on a D_MEM grant while if_req=0.
- IF_MEM / D_MEM:
  - mem_req=1 with the latched mem_we/mem_addr/mem_wdata, held stable until mem_ack=1.
  - owner=01 or 10 respectively.
  - On the edge where mem_ack=1: capture mem_rdata into the winner's rdata register, drop mem_req and mem_we, set the winner's ack, go to RESP.
- RESP:
  - Exactly one of if_ack/d_ack is 1 for this single cycle; the corresponding rdata is valid.
  - On the next edge: ack→0, owner→00, state→IDLE.
  - The requester deasserts req on the edge ending the ack cycle.
- Stores: d_rdata returns the captured mem_rdata (don't-care content), but d_ack is still pulsed.
- Latency:
  - Minimum request-to-ack is 2 cycles: req sampled in IDLE at edge N; mem_req high in cycle N+1; mem_ack in that same cycle; ack high in cycle N+2.
  - Each extra memory wait cycle adds one cycle.
  - Back-to-back grants are separated by one IDLE cycle.
- Simultaneous if_req and d_req in IDLE: data wins unless wait_cnt==MAX_WAIT, in which case fetch wins.
- A request arriving during IF_MEM/D_MEM/RESP is not sampled until the next IDLE.
- mem_ack while mem_req=0 (IDLE, RESP) is ignored.
- if_rdata/d_rdata hold their last captured value between acks.
- Reset (reset=0 at an edge, any state, including mid-transaction):
  - state→IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, owner=00, wait_cnt=0.
  - Any outstanding memory transaction is abandoned; no ack is issued for it.

Test Plan:
- Reset then single fetch, if_addr=0x40, memory acks in first mem_req cycle with 0x8C220004 → mem_addr=0x40, mem_we=0; if_ack high exactly 2 cycles after if_req sampled; if_rdata=0x8C220004; owner 01 then 00.
- Store, d_addr=0x100, d_wdata=0xDEADBEEF, d_we=1, memory delays ack 3 cycles → mem_req, mem_we and mem_wdata stay stable for 4 cycles; d_ack single pulse 5 cycles after sampling.
- if_req and d_req held high continuously, MAX_WAIT=2 → grant order D, D, F, D, D, F; wait_cnt returns to 0 after each F.
- mem_ack pulsed while in IDLE with no requests → no ack outputs, state stays IDLE; later fetch completes normally.
- reset driven 0 during D_MEM before mem_ack → next cycle mem_req=0, owner=00, no d_ack ever for that request; reissued d_req is served normally.
- d_req asserted in the RESP cycle of a fetch → not granted until the following IDLE edge; mem_addr changes only after that edge.
